// File: rtl/xge_pkt_gen.sv
// xge_pkt_gen: tester traffic generator for the MAC pkt_tx_* interface.
// Builds DA/SA/EtherType/seq/incrementing-payload frames with gap and backpressure.
module xge_pkt_gen #(
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 9600
) (
    input  logic        clk_156,
    input  logic        async_reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic [13:0] cfg_len,
    input  logic [7:0]  cfg_ipg,
    input  logic [31:0] cfg_num_pkts,
    input  logic [47:0] cfg_dst_mac,
    input  logic [47:0] cfg_src_mac,
    input  logic [15:0] cfg_ethertype,
    input  logic        pkt_tx_full,
    output logic [63:0] pkt_tx_data,
    output logic        pkt_tx_val,
    output logic        pkt_tx_sop,
    output logic        pkt_tx_eop,
    output logic [2:0]  pkt_tx_mod,
    output logic        busy,
    output logic        done,
    output logic [31:0] pkt_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        IPG,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] widx_q, widx_d;
    logic [10:0] last_q, last_d;
    logic [13:0] len_q, len_d;
    logic [7:0]  ipg_q, ipg_d;
    logic [7:0]  gap_q, gap_d;
    logic [31:0] num_q, num_d;
    logic [47:0] da_q, da_d;
    logic [47:0] sa_q, sa_d;
    logic [15:0] type_q, type_d;
    logic        stop_q, stop_d;
    logic [63:0] data_q, data_d;
    logic        val_q, val_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;
    logic [2:0]  mod_q, mod_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] cnt_q, cnt_d;

    logic [13:0]  len_clamp;
    logic [63:0]  word;
    logic [143:0] hdr;
    logic [143:0] hdr_sh;
    logic [13:0]  k;
    logic [7:0]   b;
    logic         stop_pend;
    logic         last_word;

    // Clamp the requested length into the legal frame range
    always_comb begin
        len_clamp = cfg_len;
        if (cfg_len < 14'(MIN_LEN)) begin
            len_clamp = 14'(MIN_LEN);
        end else if (cfg_len > 14'(MAX_LEN)) begin
            len_clamp = 14'(MAX_LEN);
        end
    end

    // Assemble the 8 bytes of the current word; header bytes come from a
    // shifted DA/SA/type/seq vector, the rest is the byte-index payload
    always_comb begin
        hdr    = {da_q, sa_q, type_q, cnt_q};
        word   = '0;
        k      = '0;
        b      = '0;
        hdr_sh = '0;
        for (int j = 0; j < 8; j++) begin
            k      = {widx_q, 3'b000} + 14'(j);
            hdr_sh = hdr << {k, 3'b000};
            if (k >= len_q) begin
                b = 8'h00;
            end else if (k < 14'd18) begin
                b = hdr_sh[143:136];
            end else begin
                b = k[7:0] - 8'd18;
            end
            word = {word[55:0], b};
        end
    end

    // Next-state and registered-output logic of the generator FSM
    always_comb begin
        state_d   = state_q;
        widx_d    = widx_q;
        last_d    = last_q;
        len_d     = len_q;
        ipg_d     = ipg_q;
        gap_d     = gap_q;
        num_d     = num_q;
        da_d      = da_q;
        sa_d      = sa_q;
        type_d    = type_q;
        stop_d    = stop_q;
        data_d    = '0;
        val_d     = 1'b0;
        sop_d     = 1'b0;
        eop_d     = 1'b0;
        mod_d     = 3'd0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        stop_pend = stop_q | stop;
        last_word = (widx_q == last_q);

        unique case (state_q)
            IDLE: begin
                stop_d = 1'b0;
                if (start) begin
                    len_d   = len_clamp;
                    last_d  = 11'((len_clamp - 14'd1) >> 3);
                    ipg_d   = cfg_ipg;
                    num_d   = cfg_num_pkts;
                    da_d    = cfg_dst_mac;
                    sa_d    = cfg_src_mac;
                    type_d  = cfg_ethertype;
                    widx_d  = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                stop_d = stop_pend;
                if (!pkt_tx_full) begin
                    val_d  = 1'b1;
                    data_d = word;
                    sop_d  = (widx_q == '0);
                    if (last_word) begin
                        eop_d  = 1'b1;
                        mod_d  = len_q[2:0];
                        cnt_d  = cnt_q + 32'd1;
                        widx_d = '0;
                        if (stop_pend ||
                            (num_q != '0 && cnt_q + 32'd1 == num_q)) begin
                            state_d = DONE;
                        end else if (ipg_q == 8'd0) begin
                            state_d = SEND;
                        end else begin
                            state_d = IPG;
                            gap_d   = ipg_q;
                        end
                    end else begin
                        widx_d = widx_q + 11'd1;
                    end
                end
            end
            IPG: begin
                stop_d = stop_pend;
                if (stop_pend) begin
                    state_d = DONE;
                end else if (!pkt_tx_full) begin
                    if (gap_q == 8'd1) begin
                        state_d = SEND;
                    end else begin
                        gap_d = gap_q - 8'd1;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                stop_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched configuration and output registers
    always_ff @(posedge clk_156 or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_q <= IDLE;
            widx_q  <= '0;
            last_q  <= '0;
            len_q   <= '0;
            ipg_q   <= '0;
            gap_q   <= '0;
            num_q   <= '0;
            da_q    <= '0;
            sa_q    <= '0;
            type_q  <= '0;
            stop_q  <= 1'b0;
            data_q  <= '0;
            val_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            mod_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
            last_q  <= last_d;
            len_q   <= len_d;
            ipg_q   <= ipg_d;
            gap_q   <= gap_d;
            num_q   <= num_d;
            da_q    <= da_d;
            sa_q    <= sa_d;
            type_q  <= type_d;
            stop_q  <= stop_d;
            data_q  <= data_d;
            val_q   <= val_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            mod_q   <= mod_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pkt_tx_data = data_q;
    assign pkt_tx_val  = val_q;
    assign pkt_tx_sop  = sop_q;
    assign pkt_tx_eop  = eop_q;
    assign pkt_tx_mod  = mod_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pkt_cnt     = cnt_q;

endmodule

// File: tb/tb_xge_pkt_gen.sv
// tb_xge_pkt_gen: randomized bench for xge_pkt_gen.
// Captured frames are compared against a byte-level frame reference model.
`timescale 1ns/1ps
module tb_xge_pkt_gen;

    logic        clk_156 = 1'b0;
    logic        async_reset_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [13:0] cfg_len = '0;
    logic [7:0]  cfg_ipg = '0;
    logic [31:0] cfg_num_pkts = '0;
    logic [47:0] cfg_dst_mac = '0;
    logic [47:0] cfg_src_mac = '0;
    logic [15:0] cfg_ethertype = '0;
    logic        pkt_tx_full = 1'b0;
    logic [63:0] pkt_tx_data;
    logic        pkt_tx_val;
    logic        pkt_tx_sop;
    logic        pkt_tx_eop;
    logic [2:0]  pkt_tx_mod;
    logic        busy;
    logic        done;
    logic [31:0] pkt_cnt;

    int checks = 0;
    int failures = 0;

    logic [63:0] wq[$];
    bit          sq[$];
    bit          eq[$];
    logic [2:0]  mq[$];
    int          gaps[$];
    int          idles[$];
    int          nframes;
    int          eop_cyc;
    int          done_cyc;
    int          bp_viol;
    logic [31:0] cnt_at_done;
    logic        busy_at_done;
    bit          timed_out;

    logic [63:0] xw[$];
    bit          xs[$];
    bit          xe[$];
    logic [2:0]  xm[$];

    xge_pkt_gen #(.MIN_LEN(60), .MAX_LEN(9600)) dut (
        .clk_156      (clk_156),
        .async_reset_n(async_reset_n),
        .start        (start),
        .stop         (stop),
        .cfg_len      (cfg_len),
        .cfg_ipg      (cfg_ipg),
        .cfg_num_pkts (cfg_num_pkts),
        .cfg_dst_mac  (cfg_dst_mac),
        .cfg_src_mac  (cfg_src_mac),
        .cfg_ethertype(cfg_ethertype),
        .pkt_tx_full  (pkt_tx_full),
        .pkt_tx_data  (pkt_tx_data),
        .pkt_tx_val   (pkt_tx_val),
        .pkt_tx_sop   (pkt_tx_sop),
        .pkt_tx_eop   (pkt_tx_eop),
        .pkt_tx_mod   (pkt_tx_mod),
        .busy         (busy),
        .done         (done),
        .pkt_cnt      (pkt_cnt)
    );

    always #3 clk_156 = ~clk_156;

    function automatic logic [7:0] ref_byte(input int len, input logic [31:0] seq,
                                            input int k, input logic [47:0] da,
                                            input logic [47:0] sa, input logic [15:0] et);
        if (k >= len) return 8'h00;
        if (k < 6) return da[8*(5-k) +: 8];
        if (k < 12) return sa[8*(11-k) +: 8];
        if (k < 14) return et[8*(13-k) +: 8];
        if (k < 18) return seq[8*(17-k) +: 8];
        return 8'((k - 18) % 256);
    endfunction

    task automatic build_expected(input int req_len, input int frames,
                                  input logic [47:0] da, input logic [47:0] sa,
                                  input logic [15:0] et);
        int L;
        int nw;
        logic [63:0] d;
        L = req_len;
        if (L < 60) L = 60;
        if (L > 9600) L = 9600;
        nw = (L + 7) / 8;
        xw.delete(); xs.delete(); xe.delete(); xm.delete();
        for (int f = 0; f < frames; f++) begin
            for (int w = 0; w < nw; w++) begin
                for (int bi = 0; bi < 8; bi++) begin
                    d[63-8*bi -: 8] = ref_byte(L, 32'(f), 8*w + bi, da, sa, et);
                end
                xw.push_back(d);
                xs.push_back(w == 0);
                xe.push_back(w == nw - 1);
                xm.push_back((w == nw - 1) ? 3'(L % 8) : 3'd0);
            end
        end
    endtask

    task automatic start_run(input int len, input int ipg, input int num,
                             input logic [47:0] da, input logic [47:0] sa,
                             input logic [15:0] et);
        @(negedge clk_156);
        cfg_len = 14'(len);
        cfg_ipg = 8'(ipg);
        cfg_num_pkts = 32'(num);
        cfg_dst_mac = da;
        cfg_src_mac = sa;
        cfg_ethertype = et;
        start = 1'b1;
        @(negedge clk_156);
        start = 1'b0;
    endtask

    task automatic collect(input int max_cyc, input int full_pct,
                           input int stop_f, input int stop_w,
                           input int hold_f, input int hold_w);
        int cyc = 0;
        int widx = 0;
        int gap = 0;
        int idle_in = 0;
        int hold = 0;
        int lf;
        int lw;
        bit in_frame = 0;
        bit full_prev = 0;
        wq.delete(); sq.delete(); eq.delete(); mq.delete();
        gaps.delete(); idles.delete();
        nframes = 0; eop_cyc = -1; done_cyc = -1; bp_viol = 0;
        cnt_at_done = '0; busy_at_done = 1'b1; timed_out = 1;
        while (cyc < max_cyc) begin
            @(negedge clk_156);
            cyc++;
            lf = -1;
            lw = -1;
            if (full_prev && pkt_tx_val) bp_viol++;
            if (pkt_tx_val) begin
                wq.push_back(pkt_tx_data);
                sq.push_back(pkt_tx_sop);
                eq.push_back(pkt_tx_eop);
                mq.push_back(pkt_tx_mod);
                if (pkt_tx_sop && nframes > 0) gaps.push_back(gap);
                lf = nframes;
                lw = widx;
                if (pkt_tx_eop) begin
                    nframes++;
                    idles.push_back(idle_in);
                    idle_in = 0;
                    in_frame = 0;
                    gap = 0;
                    widx = 0;
                    eop_cyc = cyc;
                end else begin
                    in_frame = 1;
                    widx++;
                end
            end else begin
                if (in_frame) idle_in++;
                else gap++;
            end
            if (done) begin
                done_cyc = cyc;
                cnt_at_done = pkt_cnt;
                busy_at_done = busy;
                timed_out = 0;
                break;
            end
            stop = pkt_tx_val && lf == stop_f && lw == stop_w;
            if (pkt_tx_val && lf == hold_f && lw == hold_w) hold = 5;
            pkt_tx_full = (hold > 0) || (int'($urandom_range(99)) < full_pct);
            if (hold > 0) hold--;
            full_prev = pkt_tx_full;
        end
        stop = 1'b0;
        pkt_tx_full = 1'b0;
    endtask

    task automatic test_reset;
        async_reset_n = 1'b0;
        repeat (3) @(negedge clk_156);
        checks++;
        if ({pkt_tx_val, pkt_tx_sop, pkt_tx_eop, busy, done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=00000",
                     {pkt_tx_val, pkt_tx_sop, pkt_tx_eop, busy, done});
        end
        checks++;
        if ({pkt_tx_data, pkt_tx_mod, pkt_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h/%0d/%0d want=0", pkt_tx_data, pkt_tx_mod, pkt_cnt);
        end
        async_reset_n = 1'b1;
        stop = 1'b1;
        @(negedge clk_156);
        stop = 1'b0;
        repeat (2) @(negedge clk_156);
        checks++;
        if ({pkt_tx_val, busy, done} !== 3'b0) begin
            failures++;
            $display("FAIL reset_idle got=%b want=000", {pkt_tx_val, busy, done});
        end
    endtask

    task automatic test_basic;
        logic [47:0] da = 48'h00AABBCCDDEE;
        logic [47:0] sa = 48'h001122334455;
        start_run(64, 0, 1, da, sa, 16'h88B5);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy got=%b want=1", busy);
        end
        collect(200, 0, -2, -2, -2, -2);
        build_expected(64, 1, da, sa, 16'h88B5);
        checks++;
        if (timed_out) begin
            failures++;
            $display("FAIL basic_timeout got=no_done want=done");
        end
        checks++;
        if (wq.size() != 8) begin
            failures++;
            $display("FAIL basic_words got=%0d want=8", wq.size());
        end
        for (int i = 0; i < xw.size() && i < wq.size(); i++) begin
            checks++;
            if ({wq[i], sq[i], eq[i], mq[i]} !== {xw[i], xs[i], xe[i], xm[i]}) begin
                failures++;
                $display("FAIL basic_w%0d got=%h/%b%b%0d want=%h/%b%b%0d", i,
                         wq[i], sq[i], eq[i], mq[i], xw[i], xs[i], xe[i], xm[i]);
            end
        end
        if (wq.size() == 8) begin
            checks++;
            if ({wq[0], wq[1], wq[2]} !==
                {64'h00AABBCCDDEE0011, 64'h2233445588B50000, 64'h0000000102030405}) begin
                failures++;
                $display("FAIL basic_hdr got=%h %h %h want=00aabbccddee0011 2233445588b50000 0000000102030405",
                         wq[0], wq[1], wq[2]);
            end
            checks++;
            if ({eq[7], mq[7]} !== {1'b1, 3'd0}) begin
                failures++;
                $display("FAIL basic_eop got=%b/%0d want=1/0", eq[7], mq[7]);
            end
        end
        checks++;
        if (done_cyc != eop_cyc + 1) begin
            failures++;
            $display("FAIL basic_done_lat got=%0d want=%0d", done_cyc, eop_cyc + 1);
        end
        checks++;
        if ({cnt_at_done, busy_at_done} !== {32'd1, 1'b0}) begin
            failures++;
            $display("FAIL basic_cnt got=%0d/%b want=1/0", cnt_at_done, busy_at_done);
        end
    endtask

    task automatic test_ipg;
        logic [47:0] da = {$urandom, $urandom};
        logic [47:0] sa = {$urandom, $urandom};
        logic [15:0] et = 16'($urandom);
        @(negedge clk_156);
        stop = 1'b1;
        @(negedge clk_156);
        stop = 1'b0;
        start_run(61, 3, 2, da, sa, et);
        cfg_len = 14'd300;
        cfg_ipg = 8'd0;
        cfg_num_pkts = 32'd7;
        cfg_dst_mac = ~da;
        start = 1'b1;
        collect(300, 0, -2, -2, -2, -2);
        start = 1'b0;
        build_expected(61, 2, da, sa, et);
        checks++;
        if (timed_out || wq.size() != xw.size()) begin
            failures++;
            $display("FAIL ipg_words got=%0d want=%0d", wq.size(), xw.size());
        end
        for (int i = 0; i < xw.size() && i < wq.size(); i++) begin
            checks++;
            if ({wq[i], sq[i], eq[i], mq[i]} !== {xw[i], xs[i], xe[i], xm[i]}) begin
                failures++;
                $display("FAIL ipg_w%0d got=%h/%b%b%0d want=%h/%b%b%0d", i,
                         wq[i], sq[i], eq[i], mq[i], xw[i], xs[i], xe[i], xm[i]);
            end
        end
        checks++;
        if (gaps.size() != 1 || gaps[0] != 3) begin
            failures++;
            $display("FAIL ipg_gap got=%0d want=3", (gaps.size() > 0) ? gaps[0] : -1);
        end
        if (wq.size() >= 11) begin
            checks++;
            if ({wq[9][15:0], wq[10][63:48]} !== 32'd1) begin
                failures++;
                $display("FAIL ipg_seq got=%h want=00000001", {wq[9][15:0], wq[10][63:48]});
            end
        end
        checks++;
        if (cnt_at_done !== 32'd2) begin
            failures++;
            $display("FAIL ipg_cnt got=%0d want=2", cnt_at_done);
        end
    endtask

    task automatic test_clamp;
        logic [47:0] da = {$urandom, $urandom};
        logic [47:0] sa = {$urandom, $urandom};
        logic [15:0] et = 16'($urandom);
        start_run(20, 0, 1, da, sa, et);
        collect(200, 0, -2, -2, -2, -2);
        build_expected(20, 1, da, sa, et);
        checks++;
        if (timed_out || wq.size() != 8 || mq[7] !== 3'd4) begin
            failures++;
            $display("FAIL clamp_min got=%0d words want=8 mod=4", wq.size());
        end
        for (int i = 0; i < xw.size() && i < wq.size(); i++) begin
            checks++;
            if ({wq[i], sq[i], eq[i], mq[i]} !== {xw[i], xs[i], xe[i], xm[i]}) begin
                failures++;
                $display("FAIL clamp_min_w%0d got=%h want=%h", i, wq[i], xw[i]);
            end
        end
        start_run(16383, 0, 1, da, sa, et);
        collect(3000, 0, -2, -2, -2, -2);
        build_expected(16383, 1, da, sa, et);
        checks++;
        if (timed_out || wq.size() != 1200) begin
            failures++;
            $display("FAIL clamp_max got=%0d words want=1200", wq.size());
        end
        for (int i = 0; i < xw.size() && i < wq.size(); i++) begin
            checks++;
            if ({wq[i], sq[i], eq[i], mq[i]} !== {xw[i], xs[i], xe[i], xm[i]}) begin
                failures++;
                $display("FAIL clamp_max_w%0d got=%h/%b%b%0d want=%h/%b%b%0d", i,
                         wq[i], sq[i], eq[i], mq[i], xw[i], xs[i], xe[i], xm[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [47:0] da = {$urandom, $urandom};
        logic [47:0] sa = {$urandom, $urandom};
        logic [15:0] et = 16'($urandom);
        start_run(100, 2, 2, da, sa, et);
        collect(300, 0, -2, -2, 0, 3);
        build_expected(100, 2, da, sa, et);
        checks++;
        if (timed_out || wq.size() != xw.size()) begin
            failures++;
            $display("FAIL bp_words got=%0d want=%0d", wq.size(), xw.size());
        end
        for (int i = 0; i < xw.size() && i < wq.size(); i++) begin
            checks++;
            if ({wq[i], sq[i], eq[i], mq[i]} !== {xw[i], xs[i], xe[i], xm[i]}) begin
                failures++;
                $display("FAIL bp_w%0d got=%h/%b%b%0d want=%h/%b%b%0d", i,
                         wq[i], sq[i], eq[i], mq[i], xw[i], xs[i], xe[i], xm[i]);
            end
        end
        checks++;
        if (idles.size() < 1 || idles[0] != 5 || bp_viol != 0) begin
            failures++;
            $display("FAIL bp_hold got=%0d idle viol=%0d want=5 idle viol=0",
                     (idles.size() > 0) ? idles[0] : -1, bp_viol);
        end
        checks++;
        if (gaps.size() != 1 || gaps[0] != 2) begin
            failures++;
            $display("FAIL bp_gap got=%0d want=2", (gaps.size() > 0) ? gaps[0] : -1);
        end
        start_run(150, 1, 3, da, sa, et);
        collect(1000, 40, -2, -2, -2, -2);
        build_expected(150, 3, da, sa, et);
        checks++;
        if (timed_out || wq.size() != xw.size() || bp_viol != 0) begin
            failures++;
            $display("FAIL bp_rand got=%0d words viol=%0d want=%0d words viol=0",
                     wq.size(), bp_viol, xw.size());
        end
        for (int i = 0; i < xw.size() && i < wq.size(); i++) begin
            checks++;
            if ({wq[i], sq[i], eq[i], mq[i]} !== {xw[i], xs[i], xe[i], xm[i]}) begin
                failures++;
                $display("FAIL bp_rand_w%0d got=%h want=%h", i, wq[i], xw[i]);
            end
        end
        checks++;
        if (cnt_at_done !== 32'd3) begin
            failures++;
            $display("FAIL bp_rand_cnt got=%0d want=3", cnt_at_done);
        end
    endtask

    task automatic test_stop;
        logic [47:0] da = {$urandom, $urandom};
        logic [47:0] sa = {$urandom, $urandom};
        logic [15:0] et = 16'($urandom);
        start_run(64, 0, 0, da, sa, et);
        collect(300, 0, 2, 2, -2, -2);
        build_expected(64, 3, da, sa, et);
        checks++;
        if (timed_out || nframes != 3 || wq.size() != xw.size()) begin
            failures++;
            $display("FAIL stop_frames got=%0d want=3", nframes);
        end
        for (int i = 0; i < xw.size() && i < wq.size(); i++) begin
            checks++;
            if ({wq[i], sq[i], eq[i], mq[i]} !== {xw[i], xs[i], xe[i], xm[i]}) begin
                failures++;
                $display("FAIL stop_w%0d got=%h want=%h", i, wq[i], xw[i]);
            end
        end
        checks++;
        if (cnt_at_done !== 32'd3 || done_cyc != eop_cyc + 1) begin
            failures++;
            $display("FAIL stop_done got=%0d cyc=%0d want=3 cyc=%0d",
                     cnt_at_done, done_cyc, eop_cyc + 1);
        end
        start_run(64, 10, 0, da, sa, et);
        collect(300, 0, 1, 7, -2, -2);
        checks++;
        if (timed_out || nframes != 2 || cnt_at_done !== 32'd2) begin
            failures++;
            $display("FAIL stop_ipg_frames got=%0d want=2", nframes);
        end
        checks++;
        if (done_cyc != eop_cyc + 2) begin
            failures++;
            $display("FAIL stop_ipg_lat got=%0d want=%0d", done_cyc, eop_cyc + 2);
        end
    endtask

    task automatic test_reset_mid;
        logic [47:0] da = {$urandom, $urandom};
        logic [47:0] sa = {$urandom, $urandom};
        logic [15:0] et = 16'($urandom);
        start_run(200, 0, 3, da, sa, et);
        repeat (6) @(negedge clk_156);
        checks++;
        if (pkt_tx_val !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_active got=%b want=1", pkt_tx_val);
        end
        #1 async_reset_n = 1'b0;
        #1;
        checks++;
        if ({pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, busy, done,
             pkt_tx_data, pkt_cnt} !== '0) begin
            failures++;
            $display("FAIL rstmid_zero got=%b%b%b/%0d/%b%b/%h/%0d want=0",
                     pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, busy, done,
                     pkt_tx_data, pkt_cnt);
        end
        @(negedge clk_156);
        async_reset_n = 1'b1;
        start_run(72, 1, 2, sa, da, et);
        collect(300, 0, -2, -2, -2, -2);
        build_expected(72, 2, sa, da, et);
        checks++;
        if (timed_out || wq.size() != xw.size()) begin
            failures++;
            $display("FAIL rstmid_words got=%0d want=%0d", wq.size(), xw.size());
        end
        for (int i = 0; i < xw.size() && i < wq.size(); i++) begin
            checks++;
            if ({wq[i], sq[i], eq[i], mq[i]} !== {xw[i], xs[i], xe[i], xm[i]}) begin
                failures++;
                $display("FAIL rstmid_w%0d got=%h want=%h", i, wq[i], xw[i]);
            end
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 4; it++) begin
            int len = $urandom_range(400, 30);
            int ipg = $urandom_range(4, 0);
            int num = $urandom_range(3, 1);
            logic [47:0] da = {$urandom, $urandom};
            logic [47:0] sa = {$urandom, $urandom};
            logic [15:0] et = 16'($urandom);
            start_run(len, ipg, num, da, sa, et);
            collect(2000, 20, -2, -2, -2, -2);
            build_expected(len, num, da, sa, et);
            checks++;
            if (timed_out || wq.size() != xw.size() || bp_viol != 0) begin
                failures++;
                $display("FAIL rand%0d_words got=%0d viol=%0d want=%0d viol=0",
                         it, wq.size(), bp_viol, xw.size());
            end
            for (int i = 0; i < xw.size() && i < wq.size(); i++) begin
                checks++;
                if ({wq[i], sq[i], eq[i], mq[i]} !== {xw[i], xs[i], xe[i], xm[i]}) begin
                    failures++;
                    $display("FAIL rand%0d_w%0d got=%h/%b%b%0d want=%h/%b%b%0d", it, i,
                             wq[i], sq[i], eq[i], mq[i], xw[i], xs[i], xe[i], xm[i]);
                end
            end
            checks++;
            if (cnt_at_done !== 32'(num)) begin
                failures++;
                $display("FAIL rand%0d_cnt got=%0d want=%0d", it, cnt_at_done, num);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_ipg;
        test_clamp;
        test_backpressure;
        test_stop;
        test_reset_mid;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
